// File: rtl/uart_tx_fifo_if.sv
// Host-write and transmitter-handshake signals of uart_tx_fifo, grouped as one bundle.
// The FIFO side uses the slave modport; the driving side (host/bench) uses master.
interface uart_tx_fifo_if #(
  parameter int AW = 4
);
  logic          wr_enH;
  logic [7:0]    wr_data;
  logic          fifo_fullH;
  logic          fifo_emptyH;
  logic [AW:0]   count;
  logic [7:0]    DBUS;
  logic          txd_startH;
  logic          txd_doneH;
  logic          tx_busyH;
  logic          ovf_errH;
  logic          ovf_clrH;

  modport slave (
    input  wr_enH, wr_data, txd_doneH, ovf_clrH,
    output fifo_fullH, fifo_emptyH, count, DBUS, txd_startH, tx_busyH, ovf_errH
  );

  modport master (
    output wr_enH, wr_data, txd_doneH, ovf_clrH,
    input  fifo_fullH, fifo_emptyH, count, DBUS, txd_startH, tx_busyH, ovf_errH
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus start sequencer feeding a UART transmitter (IDLE -> START -> WAIT_DONE).
// Optional sticky overflow flag: define UART_TX_FIFO_OVF_EN to build it.
module uart_tx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int START_CYC = 16
) (
  input  logic               sysclk,
  input  logic               rst_n,
  uart_tx_fifo_if.slave      bus
);
  localparam int SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [AW:0]     count_q, count_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [7:0]      dbus_q, dbus_d;
  logic            done_q;
  logic [7:0]      mem [DEPTH];

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            done_rise;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  // Full flag is the registered one, so a pop in the same cycle never frees room for a push
  assign push      = bus.wr_enH && !full;
  assign pop       = (state_q == IDLE) && !empty;
  assign done_rise = bus.txd_doneH & ~done_q;

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    scnt_d  = scnt_q;
    dbus_d  = dbus_q;
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    if (push) begin
      wp_d = wp_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (pop) begin
          dbus_d  = mem[rp_q];
          rp_d    = rp_q + 1'b1;
          scnt_d  = SW'(START_CYC - 1);
          state_d = START;
        end
      end
      START: begin
        if (scnt_q == '0) begin
          state_d = WAIT_DONE;
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (done_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      scnt_q  <= '0;
      dbus_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      scnt_q  <= scnt_d;
      dbus_q  <= dbus_d;
      done_q  <= bus.txd_doneH;
    end
  end

  // Storage carries no reset; stale contents are unreachable once the pointers clear
  always_ff @(posedge sysclk) begin
    if (push) begin
      mem[wp_q] <= bus.wr_data;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (bus.wr_enH && full) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clrH) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf_errH = ovf_q;
`else
  assign bus.ovf_errH = 1'b0;
`endif

  assign bus.fifo_fullH  = full;
  assign bus.fifo_emptyH = empty;
  assign bus.count       = count_q;
  assign bus.DBUS        = dbus_q;
  assign bus.txd_startH  = (state_q == START);
  assign bus.tx_busyH    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH 16, START_CYC 16).
// Expectation for ovf_errH follows UART_TX_FIFO_OVF_EN.
module tb_uart_tx_fifo;
  logic sysclk = 1'b0;
  logic rst_n  = 1'b1;

  uart_tx_fifo_if #(.AW(4)) bus ();

  uart_tx_fifo #(
    .DEPTH     (16),
    .AW        (4),
    .START_CYC (16)
  ) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

`ifdef UART_TX_FIFO_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  int checks  = 0;
  int errors  = 0;
  int max_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; all sampling happens 1 time unit after the rising edge
  task automatic step();
    @(posedge sysclk);
    #1;
    if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!bus.txd_startH && n < 200) begin
      step();
      n++;
    end
    check_val("wait_start", 32'(bus.txd_startH), 32'd1);
  endtask

  task automatic wait_start_end();
    int n = 0;
    while (bus.txd_startH && n < 200) begin
      step();
      n++;
    end
    check_val("wait_start_end", 32'(bus.txd_startH), 32'd0);
  endtask

  task automatic send_done();
    bus.txd_doneH = 1'b1;
    step();
    bus.txd_doneH = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_dbus"},  32'(bus.DBUS),        32'h00);
    check_val({tag, "_start"}, 32'(bus.txd_startH),  32'd0);
    check_val({tag, "_busy"},  32'(bus.tx_busyH),    32'd0);
    check_val({tag, "_ovf"},   32'(bus.ovf_errH),    32'd0);
    check_val({tag, "_empty"}, 32'(bus.fifo_emptyH), 32'd1);
    check_val({tag, "_full"},  32'(bus.fifo_fullH),  32'd0);
    check_val({tag, "_count"}, 32'(bus.count),       32'd0);
  endtask

  function automatic logic [7:0] strm_byte(input int k);
    return 8'((k * 37) + 11);
  endfunction

  initial begin
    int n;
    int seen;
    bus.wr_enH    = 1'b0;
    bus.wr_data   = 8'h00;
    bus.txd_doneH = 1'b0;
    bus.ovf_clrH  = 1'b0;

    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("por");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single byte, with a done pulse during START that must be ignored
    bus.wr_enH  = 1'b1;
    bus.wr_data = 8'hA5;
    step();
    bus.wr_enH  = 1'b0;
    check_val("single_empty_n1", 32'(bus.fifo_emptyH), 32'd0);
    check_val("single_count_n1", 32'(bus.count),       32'd1);
    check_val("single_start_n1", 32'(bus.txd_startH),  32'd0);
    step();
    check_val("single_dbus",     32'(bus.DBUS),        32'hA5);
    check_val("single_start_n2", 32'(bus.txd_startH),  32'd1);
    check_val("single_count_n2", 32'(bus.count),       32'd0);
    check_val("single_busy",     32'(bus.tx_busyH),    32'd1);
    n = 1;
    bus.txd_doneH = 1'b1;
    step();
    if (bus.txd_startH) n++;
    bus.txd_doneH = 1'b0;
    while (bus.txd_startH && n < 100) begin
      step();
      if (bus.txd_startH) n++;
    end
    check_val("single_start_len", 32'(n), 32'd16);
    step();
    step();
    step();
    check_val("single_done_in_start_ignored", 32'(bus.tx_busyH), 32'd1);
    send_done();
    check_val("single_idle_after_done", 32'(bus.tx_busyH), 32'd0);
    $display("single byte a5 sent");

    // Ordered burst 01..05
    max_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      bus.wr_enH  = 1'b1;
      bus.wr_data = 8'(i + 1);
      step();
    end
    bus.wr_enH = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_start();
      check_val($sformatf("burst_dbus%0d", i), 32'(bus.DBUS), 32'(i + 1));
      $display("burst byte %0d dbus %02h", i, bus.DBUS);
      wait_start_end();
      send_done();
    end
    check_val("burst_peak_count", 32'(max_cnt), 32'd4);
    check_val("burst_end_busy",  32'(bus.tx_busyH),    32'd0);
    check_val("burst_end_empty", 32'(bus.fifo_emptyH), 32'd1);

    // Full / overflow with the transmitter stalled
    for (int i = 0; i < 18; i++) begin
      bus.wr_enH  = 1'b1;
      bus.wr_data = 8'(8'h10 + i);
      step();
    end
    bus.wr_enH = 1'b0;
    check_val("full_flag",  32'(bus.fifo_fullH), 32'd1);
    check_val("full_count", 32'(bus.count),      32'd16);
    check_val("full_inflight", 32'(bus.DBUS),    32'h10);
    step();
    step();
    check_val("ovf_sticky", 32'(bus.ovf_errH), 32'(OVF_EXP));
    bus.ovf_clrH = 1'b1;
    step();
    bus.ovf_clrH = 1'b0;
    check_val("ovf_cleared", 32'(bus.ovf_errH), 32'd0);
    wait_start_end();
    send_done();
    for (int i = 1; i <= 16; i++) begin
      wait_start();
      check_val($sformatf("drain_dbus%0d", i), 32'(bus.DBUS), 32'(8'h10 + i));
      $display("drain byte %0d dbus %02h", i, bus.DBUS);
      wait_start_end();
      send_done();
    end
    step();
    check_val("drain_empty", 32'(bus.fifo_emptyH), 32'd1);
    check_val("drain_busy",  32'(bus.tx_busyH),    32'd0);
    check_val("drain_count", 32'(bus.count),       32'd0);

    // Streaming with a push coincident with every pop, across pointer wrap
    bus.wr_enH  = 1'b1;
    bus.wr_data = strm_byte(0);
    step();
    bus.wr_enH = 1'b0;
    for (int k = 0; k < 40; k++) begin
      check_val($sformatf("strm_idle%0d", k),  32'(bus.tx_busyH), 32'd0);
      check_val($sformatf("strm_cnt_pre%0d", k), 32'(bus.count), 32'd1);
      if (k < 39) begin
        bus.wr_enH  = 1'b1;
        bus.wr_data = strm_byte(k + 1);
      end
      step();
      bus.wr_enH = 1'b0;
      check_val($sformatf("strm_cnt%0d", k),  32'(bus.count), (k < 39) ? 32'd1 : 32'd0);
      check_val($sformatf("strm_dbus%0d", k), 32'(bus.DBUS),  32'(strm_byte(k)));
      check_val($sformatf("strm_start%0d", k), 32'(bus.txd_startH), 32'd1);
      wait_start_end();
      send_done();
    end
    $display("stream of 40 bytes complete");

    // Reset in the middle of a burst
    for (int i = 0; i < 3; i++) begin
      bus.wr_enH  = 1'b1;
      bus.wr_data = 8'(8'hC1 + i);
      step();
    end
    bus.wr_enH = 1'b0;
    wait_start();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.txd_startH) seen++;
    end
    check_val("midrst_no_start", 32'(seen), 32'd0);
    check_val("midrst_empty", 32'(bus.fifo_emptyH), 32'd1);
    check_val("midrst_dbus",  32'(bus.DBUS),        32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and start sequencer that sits directly upstream of the UART transmitter. Host logic pushes bytes at system clock rate. The block queues them and presents them one at a time on `DBUS`. It drives `txd_startH` and waits for `txd_doneH` before launching the next byte. This decouples bursty producers from the slow baud-rate-paced serial line.

## Interface

- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `AW`, 4: pointer width; must equal log2(`DEPTH`).
- `START_CYC`, 16: sysclk cycles `txd_startH` is held high per byte; must be ≥ one `bclk` period in sysclk cycles.
- `sysclk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `wr_enH` in 1: push request for `wr_data`.
- `wr_data` in 8: byte to queue.
- `fifo_fullH` out 1: `count == DEPTH`.
- `fifo_emptyH` out 1: `count == 0`.
- `count` out AW+1: bytes stored, excluding the byte in flight.
- `DBUS` out 8: byte for the transmitter, registered.
- `txd_startH` out 1: transmitter start request.
- `txd_doneH` in 1: transmitter done level, synchronous to `sysclk`.
- `tx_busyH` out 1: high when the FSM is not IDLE.
- `ovf_errH` out 1: sticky overflow flag (see Configuration).
- `ovf_clrH` in 1: clears `ovf_errH`.

## Operation

- Storage: `DEPTH`×8 register array, write pointer `wp` and read pointer `rp`, each AW bits, wrapping modulo `DEPTH`. The count register is separate; there is no full/empty inference from the pointers.
- Push: accepted when `wr_enH && !fifo_fullH` using the current-cycle flag. It writes `mem[wp]` and increments `wp`. A push while full is dropped, and memory, pointers and count are unchanged.
- Pop: occurs only on the IDLE→START transition. It loads `DBUS <= mem[rp]` and increments `rp`.
- Push and pop in the same cycle: both happen, and `count` is unchanged.
- Push and pop while full: the push is still rejected, because the flag is sampled before the pop.
- FSM states:
  - IDLE: `txd_startH`=0. If `!fifo_emptyH`, pop and go to START, loading the start counter with `START_CYC-1`.
  - START: `txd_startH`=1. Decrement the counter each cycle. At 0, go to WAIT_DONE.
  - WAIT_DONE: `txd_startH`=0. Wait for a rising edge of `txd_doneH`, defined as `txd_doneH & ~done_q`, where `done_q` is the previous-cycle sample. On the edge, go to IDLE.
- Edges of `txd_doneH` outside WAIT_DONE are ignored.
- `DBUS` holds its value from the pop until the next pop, including through IDLE.
- Reset (asynchronous, any state):
  - FSM → IDLE; pointers, `count` and start counter → 0.
  - `DBUS`=8'h00, `txd_startH`=0, `tx_busyH`=0, `ovf_errH`=0, `done_q`=0.
  - `fifo_emptyH`=1, `fifo_fullH`=0.
  - Queued bytes are discarded; a byte already on the line is abandoned.

## Timing

- Write to an empty, idle block with `wr_enH` high in cycle N:
  - `fifo_emptyH` falls in N+1.
  - Pop at the end of N+1.
  - `DBUS` is valid and `txd_startH` rises in N+2.
  - `count` returns to 0 in N+2.
- `txd_startH` is high for exactly `START_CYC` consecutive cycles.
- `txd_doneH` rising in cycle M during WAIT_DONE puts the FSM in IDLE in M+1. With data queued, `txd_startH` rises again in M+2.
- Flags and `count` are registered and update the cycle after the push or pop.

## Configuration

- `UART_TX_FIFO_OVF_EN` defined:
  - `ovf_errH` sets on any push attempt while full.
  - It stays set until `ovf_clrH` is sampled high.
  - Set has priority over clear in the same cycle.
- Not defined: `ovf_errH` is tied to 0, `ovf_clrH` is ignored, and no flag register is built.

## Test plan

- Reset mid-burst: push 3 bytes and assert `rst_n`=0 during START → all outputs return to reset values; after release, no `txd_startH` without new pushes.
- Single byte: push 8'hA5 into an idle block → `DBUS`=8'hA5 and `txd_startH` high 2 cycles later for 16 cycles; a `txd_doneH` pulse returns `tx_busyH` to 0.
- Ordered burst: push 8'h01..8'h05 back-to-back, then pulse `txd_doneH` after each start window → `DBUS` shows 01,02,03,04,05 in order; `count` peaks at 4.
- Full/overflow: with the transmitter stalled (no done), push 18 bytes:
  - Result: 1 in flight, 16 stored, `fifo_fullH`=1, last push dropped.
  - With the macro: `ovf_errH`=1 until `ovf_clrH`.
  - Without the macro: `ovf_errH` stays 0.
- Wrap and simultaneous events:
  - Stream 40 bytes with a push in the same cycle as each pop → data intact across pointer wrap, and `count` unchanged on coincident cycles.
  - A `txd_doneH` edge during START is ignored.
